// File: rtl/sr_latch_ctrl_if.sv
// sr_latch_ctrl_if: requester handshakes plus latch drive and feedback pins for sr_latch_ctrl
//   req_a/req_b  : level requests, held until the matching grant
//   op_a/op_b    : 1 = set latch, 0 = reset latch, sampled on the grant edge
//   gnt_a/gnt_b  : one-cycle registered grants
//   sbar/rbar    : active-low set/reset drives to the NAND latch
//   q_fb         : synchronized latch Q feedback
//   q_exp        : expected latch state
//   busy         : controller not idle
//   err/err_clr  : sticky feedback mismatch flag and its clear
//   master modport is the controller, slave modport is the environment
interface sr_latch_ctrl_if;
    logic req_a, req_b, op_a, op_b, gnt_a, gnt_b;
    logic sbar, rbar, q_fb, q_exp, busy, err, err_clr;
    modport master (
        input  req_a, req_b, op_a, op_b, q_fb, err_clr,
        output gnt_a, gnt_b, sbar, rbar, q_exp, busy, err
    );
    modport slave (
        output req_a, req_b, op_a, op_b, q_fb, err_clr,
        input  gnt_a, gnt_b, sbar, rbar, q_exp, busy, err
    );
endinterface

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: round-robin set/reset controller for a cross-coupled NAND SR latch
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : sr_latch_ctrl_if.master (requests, grants, latch drives, feedback, status)
//   PULSE_W : cycles the active drive is held low (1..15)
//   GUARD_W : cycles both drives are high after a pulse before checking (1..15)
module sr_latch_ctrl #(
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    sr_latch_ctrl_if.master bus
);
    typedef enum logic [2:0] {BOOT, PULSE, GUARD, CHECK, IDLE} state_t;
    localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
    localparam logic [3:0] GUARD_LD = 4'(GUARD_W - 1);
    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_ptr, w_ptr_nxt;
    logic       r_op, w_op_nxt;
    logic       r_gnt_a, r_gnt_b;
    logic       r_sbar, r_rbar, w_sbar_nxt, w_rbar_nxt;
    logic       r_q_exp, w_q_exp_nxt;
    logic       r_err, w_err_nxt;
    logic       r_busy;
    logic       w_arb, w_pick_a, w_pick_b, w_mis;
    always_comb begin
        w_arb       = r_state == IDLE || r_state == CHECK;
        // r_ptr = 0 favours A on a tie, 1 favours B
        w_pick_a    = w_arb && bus.req_a && (!bus.req_b || !r_ptr);
        w_pick_b    = w_arb && bus.req_b && (!bus.req_a || r_ptr);
        w_mis       = r_state == CHECK && bus.q_fb != r_q_exp;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_op_nxt    = r_op;
        w_q_exp_nxt = r_q_exp;
        // a fresh mismatch outranks a clear on the same edge
        w_err_nxt   = w_mis || (r_err && !bus.err_clr);
        case (r_state)
            BOOT: begin
                w_state_nxt = PULSE;
                w_op_nxt    = 1'b0;
                w_cnt_nxt   = PULSE_LD;
            end
            PULSE: begin
                w_state_nxt = r_cnt == 4'd0 ? GUARD : PULSE;
                w_cnt_nxt   = r_cnt == 4'd0 ? GUARD_LD : r_cnt - 4'd1;
                w_q_exp_nxt = r_cnt == 4'd0 ? r_op : r_q_exp;
            end
            GUARD: begin
                w_state_nxt = r_cnt == 4'd0 ? CHECK : GUARD;
                w_cnt_nxt   = r_cnt - 4'd1;
            end
            CHECK, IDLE: w_state_nxt = IDLE;
            default: w_state_nxt = BOOT;
        endcase
        if (w_pick_a || w_pick_b) begin
            w_state_nxt = PULSE;
            w_cnt_nxt   = PULSE_LD;
            w_op_nxt    = w_pick_a ? bus.op_a : bus.op_b;
            w_ptr_nxt   = w_pick_a;
        end
        // drives derive from the next state alone, so both can never be low together
        w_sbar_nxt = !(w_state_nxt == PULSE && w_op_nxt);
        w_rbar_nxt = !(w_state_nxt == PULSE && !w_op_nxt);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= BOOT;
            r_cnt   <= 4'd0;
            r_ptr   <= 1'b0;
            r_op    <= 1'b0;
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_sbar  <= 1'b1;
            r_rbar  <= 1'b1;
            r_q_exp <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_op    <= w_op_nxt;
            r_gnt_a <= w_pick_a;
            r_gnt_b <= w_pick_b;
            r_sbar  <= w_sbar_nxt;
            r_rbar  <= w_rbar_nxt;
            r_q_exp <= w_q_exp_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_state_nxt != IDLE;
        end
    end
    assign bus.gnt_a = r_gnt_a;
    assign bus.gnt_b = r_gnt_b;
    assign bus.sbar  = r_sbar;
    assign bus.rbar  = r_rbar;
    assign bus.q_exp = r_q_exp;
    assign bus.busy  = r_busy;
    assign bus.err   = r_err;
endmodule
